// File: rtl/regfile_fwd_sb_if.sv
// Decode/write-back bus for regfile_fwd_sb: forwarding sources, write ports,
// issue/kill scoreboard events and the decode-side results.
interface regfile_fwd_sb_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] d_srcA;
    logic [ADDR_W-1:0] d_srcB;
    logic              d_useValP;
    logic [DATA_W-1:0] d_valP;
    logic              d_issue;
    logic [ADDR_W-1:0] d_dstE;
    logic [ADDR_W-1:0] d_dstM;
    logic [ADDR_W-1:0] e_dstE;
    logic [DATA_W-1:0] e_valE;
    logic [ADDR_W-1:0] e_dstM;
    logic [ADDR_W-1:0] M_dstE;
    logic [ADDR_W-1:0] M_dstM;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] m_valM;
    logic [ADDR_W-1:0] W_dstE;
    logic [ADDR_W-1:0] W_dstM;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic              kill_valid;
    logic [ADDR_W-1:0] kill_dstE;
    logic [ADDR_W-1:0] kill_dstM;
    logic [DATA_W-1:0] d_valA;
    logic [DATA_W-1:0] d_valB;
    logic              d_stall;
    logic [NREGS-1:0]  reg_busy;
    logic              sb_err;

    modport master (
        output d_srcA, d_srcB, d_useValP, d_valP, d_issue, d_dstE, d_dstM,
               e_dstE, e_valE, e_dstM, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM, kill_valid, kill_dstE, kill_dstM,
        input  d_valA, d_valB, d_stall, reg_busy, sb_err
    );

    modport slave (
        input  d_srcA, d_srcB, d_useValP, d_valP, d_issue, d_dstE, d_dstM,
               e_dstE, e_valE, e_dstM, M_dstE, M_dstM, M_valE, m_valM,
               W_dstE, W_dstM, W_valE, W_valM, kill_valid, kill_dstE, kill_dstM,
        output d_valA, d_valB, d_stall, reg_busy, sb_err
    );
endinterface

// File: rtl/regfile_fwd_sb.sv
// Register file with two write-back ports, forwarded decode reads,
// load-use stall detection and a per-register pending-write scoreboard.
module regfile_fwd_sb #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NREGS   = 15,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned NONE_ID = 15,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            reset,
    regfile_fwd_sb_if.slave bus
);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [ADDR_W-1:0] NREGS_A = ADDR_W'(NREGS);
    localparam logic [ADDR_W-1:0] NONE_A  = ADDR_W'(NONE_ID);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q  [NREGS];
    logic [CNT_W-1:0]  cnt_d  [NREGS];
    logic              sb_err_q;
    logic              sb_err_d;

    logic [ADDR_W-1:0] src    [2];
    logic [DATA_W-1:0] fwd_val[2];
    logic              stall_c;
    logic              issue_ok;
    logic              w_e_ok;
    logic              w_m_ok;
    logic [NREGS-1:0]  busy_c;

    assign w_e_ok = (bus.W_dstE < NREGS_A);
    assign w_m_ok = (bus.W_dstM < NREGS_A);

    // Per-lane forwarding: nearest pipeline stage wins, register file last.
    always_comb begin
        src[0] = bus.d_srcA;
        src[1] = bus.d_srcB;
        for (int l = 0; l < 2; l++) begin
            fwd_val[l] = '0;
            if (src[l] != NONE_A && src[l] < NREGS_A) begin
                if (src[l] == bus.e_dstE)      fwd_val[l] = bus.e_valE;
                else if (src[l] == bus.M_dstM) fwd_val[l] = bus.m_valM;
                else if (src[l] == bus.M_dstE) fwd_val[l] = bus.M_valE;
                else if (src[l] == bus.W_dstM) fwd_val[l] = bus.W_valM;
                else if (src[l] == bus.W_dstE) fwd_val[l] = bus.W_valE;
                else                           fwd_val[l] = regs_q[src[l]];
            end
        end
    end

    assign bus.d_valA = bus.d_useValP ? bus.d_valP : fwd_val[0];
    assign bus.d_valB = fwd_val[1];

    // A load still in execute cannot be forwarded; valP use hides the A side.
    always_comb begin
        stall_c = 1'b0;
        if (bus.e_dstM != NONE_A) begin
            stall_c = ((bus.d_srcA == bus.e_dstM) && !bus.d_useValP) ||
                      (bus.d_srcB == bus.e_dstM);
        end
    end

    assign bus.d_stall = stall_c;
    assign issue_ok    = bus.d_issue && !stall_c;

    // Register write: M port applied last so it wins a same-index collision.
    always_comb begin
        regs_d = regs_q;
        if (w_e_ok) regs_d[bus.W_dstE] = bus.W_valE;
        if (w_m_ok) regs_d[bus.W_dstM] = bus.W_valM;
    end

    // Scoreboard: sum all increments/decrements per register, then clamp.
    always_comb begin
        int sum;
        sum      = 0;
        sb_err_d = sb_err_q;
        for (int r = 0; r < NREGS; r++) begin
            sum = int'(cnt_q[r]);
            if (issue_ok && bus.d_dstE == ADDR_W'(r)) sum = sum + 1;
            if (issue_ok && bus.d_dstM == ADDR_W'(r)) sum = sum + 1;
            if (bus.W_dstE == ADDR_W'(r))             sum = sum - 1;
            if (bus.W_dstM == ADDR_W'(r))             sum = sum - 1;
            if (bus.kill_valid && bus.kill_dstE == ADDR_W'(r)) sum = sum - 1;
            if (bus.kill_valid && bus.kill_dstM == ADDR_W'(r)) sum = sum - 1;
            if (sum > int'(CNT_MAX)) begin
                cnt_d[r] = CNT_W'(CNT_MAX);
                sb_err_d = 1'b1;
            end else if (sum < 0) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        busy_c = '0;
        for (int r = 0; r < NREGS; r++) busy_c[r] = |cnt_q[r];
    end

    assign bus.reg_busy = busy_c;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: doc/regfile_fwd_sb.md
Name: regfile_fwd_sb

Overview:
- Parametrised successor to the pipeline decode/write-back stage.
- Holds the architectural register file with two synchronous write ports, both written at the write-back stage.
- Provides two forwarded read ports for decode: srcA and srcB.
- Adds a pending-write scoreboard and load-use stall detection, which the earlier stage lacked.
- Sits between fetch/decode pipeline registers and the execute stage; fully synchronous; decode-side outputs are combinational from state and inputs.

Parameters:
- DATA_W, 64, register and value width in bits.
- NREGS, 15, number of architectural registers (indices 0..NREGS-1).
- ADDR_W, 4, register index width; requires NREGS < 2^ADDR_W.
- NONE_ID, 15, "no register" index; must be >= NREGS.
- CNT_W, 2, width of each per-register pending-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- d_srcA, d_srcB  in  ADDR_W  decode source registers (NONE_ID = unused).
- d_useValP  in  1  valA takes d_valP (jXX/call).
- d_valP  in  DATA_W  incremented PC from decode.
- d_issue  in  1  decode instruction advances to E this cycle.
- d_dstE, d_dstM  in  ADDR_W  destinations of the issuing instruction.
- e_dstE  in  ADDR_W  execute-stage E destination.
- e_valE  in  DATA_W  execute-stage ALU result.
- e_dstM  in  ADDR_W  execute-stage load destination (value not yet available).
- M_dstE, M_dstM  in  ADDR_W  memory-stage destinations.
- M_valE, m_valM  in  DATA_W  memory-stage values.
- W_dstE, W_dstM  in  ADDR_W  write-back destinations; these are the write ports.
- W_valE, W_valM  in  DATA_W  write-back values.
- kill_valid  in  1  a squashed instruction is cancelled this cycle.
- kill_dstE, kill_dstM  in  ADDR_W  destinations of the squashed instruction.
- d_valA, d_valB  out  DATA_W  forwarded operands.
- d_stall  out  1  load-use hazard; decode must hold.
- reg_busy  out  NREGS  bit r = 1 when counter r is non-zero.
- sb_err  out  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - all R[r] = 0, all counters = 0, sb_err = 0.
  - Writes, issue and kill are ignored in that cycle.
  - Mid-operation reset discards in-flight state; the following cycle reads zeros.
- Writes at posedge:
  - W_dstE < NREGS writes W_valE; W_dstM < NREGS writes W_valM.
  - If W_dstE == W_dstM, W_valM wins.
  - Indices >= NREGS, including NONE_ID, are not written.
- Read/forward is combinational and evaluated independently for A and B.
  - A only: if d_useValP, d_valA = d_valP.
  - Otherwise the first match of src against the sources below supplies the value, in this priority order:
    1. e_dstE / e_valE
    2. M_dstM / m_valM
    3. M_dstE / M_valE
    4. W_dstM / W_valM
    5. W_dstE / W_valE
    6. R[src]
  - A match requires src != NONE_ID.
  - src == NONE_ID or src >= NREGS gives 0; no latched old value.
  - Forwarding from W gives same-cycle write-through; the register write lands next edge.
- d_stall = 1 when e_dstM != NONE_ID and (d_srcA == e_dstM or d_srcB == e_dstM), with d_useValP masking the A side.
- Scoreboard: one CNT_W-bit counter per register, updated at posedge.
  - +1 for each of d_dstE and d_dstM < NREGS when d_issue=1 and d_stall=0; if both name the same register, +2.
  - -1 for each valid W_dstE and W_dstM written (same-register case: -2).
  - -1 per valid kill_dst when kill_valid=1.
  - Net delta is summed per register in one cycle; simultaneous issue and retire on the same register leaves the count unchanged.
  - A result > 2^CNT_W-1 saturates at max and sets sb_err.
  - A result < 0 clamps at 0 and sets sb_err.
  - sb_err clears only on reset.
- d_issue while d_stall=1 is ignored by the scoreboard.
- reg_busy is derived directly from the counters; no extra latency.

Test Plan:
- Reset with R preloaded by writes: assert reset one cycle, read srcA=3 -> d_valA=0, reg_busy=0, sb_err=0.
- Write W_dstE=2, W_valE=0x55, no other matches: same cycle srcA=2 -> 0x55 (write-through); next cycle, W idle -> 0x55 from R.
- Priority: srcB=5 with e_dstE=5/0x11, M_dstM=5/0x22, W_dstE=5/0x33 -> d_valB=0x11; drop e -> 0x22; drop M -> 0x33.
- Dual-write collision W_dstE=W_dstM=7 (valE=1, valM=2) -> R[7]=2 after edge; counter 7 decrements by 2.
- Load-use: e_dstM=4, d_srcA=4 -> d_stall=1 and d_issue ignored; d_useValP=1 -> d_stall=0, d_valA=d_valP.
- Scoreboard: issue dstE=1 four times with CNT_W=2 -> count saturates at 3 and sb_err=1; retire three times -> reg_busy[1]=0; a further retire keeps count 0 and sb_err stays 1.
